// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// default timing constants and small helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

    localparam int   CLKS_PER_BIT = 868;
    localparam int   DATA_BITS    = 8;
    localparam logic IDLE_LEVEL   = 1'b1;

    // Counter value at which the start bit is sampled (its midpoint).
    function automatic int half_bit_last(input int cpb);
        return (cpb / 2) - 1;
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Byte delivery bundle between the UART receiver (master) and its consumer (slave).
interface uart_receiver_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 data_ack;
    logic                 framing_err;
    logic                 overrun;
    logic                 busy;

    modport master (
        output data, data_valid, framing_err, overrun, busy,
        input  data_ack
    );

    modport slave (
        input  data, data_valid, framing_err, overrun, busy,
        output data_ack
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset
// value is a parameter so an idle-high line does not look like a start edge.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic ff1_q;
    logic ff2_q;

    // Synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= RST_VAL;
            ff2_q <= RST_VAL;
        end else begin
            ff1_q <= d;
            ff2_q <= ff1_q;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver with valid/ack byte delivery and
// framing/overrun error pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RsRx,
    uart_receiver_if.master  rx_if
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(half_bit_last(CLKS_PER_BIT));
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 framing_err_q, framing_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic                 commit_s;

    uart_sync2 #(.RST_VAL(IDLE_LEVEL)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (RsRx),
        .q     (rx_s)
    );

    // Next-state, datapath and handshake logic
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        idx_d         = idx_q;
        shift_d       = shift_q;
        data_d        = data_q;
        data_valid_d  = data_valid_q;
        framing_err_d = 1'b0;
        overrun_d     = 1'b0;
        commit_s      = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (rx_s == 1'b0) begin
                    state_d   = RX_START;
                    bit_cnt_d = '0;
                end else begin
                    state_d   = RX_IDLE;
                end
            end
            RX_START: begin
                if (bit_cnt_q == CNT_HALF) begin
                    bit_cnt_d = '0;
                    idx_d     = '0;
                    if (rx_s == 1'b0) begin
                        state_d = RX_DATA;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            // Sampling is offset by half a bit, so the end of each count lands mid-bit
            RX_DATA: begin
                if (bit_cnt_q == CNT_LAST) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = '0;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = RX_STOP;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (bit_cnt_q == CNT_LAST) begin
                    bit_cnt_d     = '0;
                    commit_s      = rx_s;
                    framing_err_d = ~rx_s;
                    state_d       = rx_s ? RX_IDLE : RX_WAIT_HIGH;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s == 1'b1) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_WAIT_HIGH;
                end
            end
            default: begin
                state_d   = RX_IDLE;
                bit_cnt_d = '0;
                idx_d     = '0;
            end
        endcase

        // An ack in the commit cycle frees the holding register for the new byte
        if (commit_s) begin
            if (!data_valid_q || rx_if.data_ack) begin
                data_d       = shift_q;
                data_valid_d = 1'b1;
            end else begin
                overrun_d    = 1'b1;
            end
        end else if (data_valid_q && rx_if.data_ack) begin
            data_valid_d = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end

        busy_d = (state_d != RX_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RX_IDLE;
            bit_cnt_q     <= '0;
            idx_q         <= '0;
            shift_q       <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            idx_q         <= idx_d;
            shift_q       <= shift_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

    assign rx_if.data        = data_q;
    assign rx_if.data_valid  = data_valid_q;
    assign rx_if.framing_err = framing_err_q;
    assign rx_if.overrun     = overrun_q;
    assign rx_if.busy        = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit: frame table plus
// hand-written sequences for back-to-back, framing, overrun, glitch and reset.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic clk;
    logic rst_n;
    logic RsRx;

    uart_receiver_if rx_if ();

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RsRx  (RsRx),
        .rx_if (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;

    // Pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (rst_n && rx_if.framing_err) ferr_cnt++;
        if (rst_n && rx_if.overrun)     ovr_cnt++;
    end

    typedef struct {
        logic [7:0] tx;
        int         stops;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        RsRx = v;
        repeat (CPB) @(negedge clk);
    endtask

    // Must be called at a negedge; returns at a negedge after the last stop bit
    task automatic send_frame(input logic [7:0] b, input int stops, input logic stop_val);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        for (int s = 0; s < stops; s++) drive_bit(stop_val);
    endtask

    task automatic ack_pulse();
        rx_if.data_ack = 1'b1;
        @(negedge clk);
        rx_if.data_ack = 1'b0;
    endtask

    int lat;
    int f0, o0, n;
    logic [7:0] got [2];

    initial begin
        vecs[0] = '{8'h5A, 1, 8'h5A};
        vecs[1] = '{8'h3C, 2, 8'h3C};
        vecs[2] = '{8'hFF, 2, 8'hFF};
        vecs[3] = '{8'h00, 1, 8'h00};
        vecs[4] = '{8'h80, 1, 8'h80};

        rst_n = 1'b0;
        RsRx = 1'b1;
        rx_if.data_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data",  32'(rx_if.data), 32'h0);
        check("reset_valid", 32'(rx_if.data_valid), 32'h0);
        check("reset_flags", {29'd0, rx_if.framing_err, rx_if.overrun, rx_if.busy}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Frame 0xA5 with latency measurement from the start edge
        f0 = ferr_cnt;
        lat = 0;
        fork
            send_frame(8'hA5, 1, 1'b1);
            begin
                while (!rx_if.data_valid && lat < 300) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("a5_data",  32'(rx_if.data), 32'hA5);
        check("a5_valid", 32'(rx_if.data_valid), 32'h1);
        check("a5_latency_in_window", 32'((lat >= 153) && (lat <= 156)), 32'h1);
        check("a5_no_ferr", 32'(ferr_cnt - f0), 32'h0);
        ack_pulse();
        check("a5_ack_clears", 32'(rx_if.data_valid), 32'h0);

        // Table of single frames, each acked after delivery
        for (int i = 0; i < 5; i++) begin
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            send_frame(vecs[i].tx, vecs[i].stops, 1'b1);
            check($sformatf("vec%0d_data", i), 32'(rx_if.data), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_valid", i), 32'(rx_if.data_valid), 32'h1);
            check($sformatf("vec%0d_errs", i), 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'h0);
            ack_pulse();
            check($sformatf("vec%0d_cleared", i), 32'(rx_if.data_valid), 32'h0);
        end

        // Back-to-back 0x3C, 0xFF with two stop bits, consumer acks each
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        fork
            begin
                send_frame(8'h3C, 2, 1'b1);
                send_frame(8'hFF, 2, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    n = 0;
                    while (!rx_if.data_valid && n < 400) begin
                        @(negedge clk);
                        n++;
                    end
                    got[k] = rx_if.data;
                    ack_pulse();
                end
            end
        join
        check("b2b_first",  32'(got[0]), 32'h3C);
        check("b2b_second", 32'(got[1]), 32'hFF);
        check("b2b_no_errs", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'h0);

        // Framing error on 0x55, then a held break line
        f0 = ferr_cnt;
        send_frame(8'h55, 1, 1'b0);
        repeat (100) @(negedge clk);
        check("ferr_once", 32'(ferr_cnt - f0), 32'h1);
        check("ferr_no_valid", 32'(rx_if.data_valid), 32'h0);
        check("ferr_wait_busy", 32'(rx_if.busy), 32'h1);
        RsRx = 1'b1;
        repeat (5) @(negedge clk);
        check("ferr_idle_again", 32'(rx_if.busy), 32'h0);
        send_frame(8'h12, 1, 1'b1);
        check("after_ferr_data", 32'(rx_if.data), 32'h12);
        check("after_ferr_count", 32'(ferr_cnt - f0), 32'h1);
        ack_pulse();

        // Overrun: 0x01 not acked, then 0x02
        o0 = ovr_cnt;
        send_frame(8'h01, 1, 1'b1);
        send_frame(8'h02, 1, 1'b1);
        check("ovr_pulse", 32'(ovr_cnt - o0), 32'h1);
        check("ovr_data_kept", 32'(rx_if.data), 32'h01);
        check("ovr_valid_kept", 32'(rx_if.data_valid), 32'h1);
        ack_pulse();
        check("ovr_ack_clears", 32'(rx_if.data_valid), 32'h0);

        // Ack landing in the commit cycle replaces the byte without overrun
        send_frame(8'h01, 1, 1'b1);
        o0 = ovr_cnt;
        fork
            send_frame(8'h02, 1, 1'b1);
            begin
                repeat (154) @(negedge clk);
                ack_pulse();
            end
        join
        check("ack_commit_data", 32'(rx_if.data), 32'h02);
        check("ack_commit_valid", 32'(rx_if.data_valid), 32'h1);
        check("ack_commit_no_ovr", 32'(ovr_cnt - o0), 32'h0);

        // 5-cycle glitch: start is rejected at mid-bit
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        RsRx = 1'b0;
        repeat (5) @(negedge clk);
        RsRx = 1'b1;
        check("glitch_busy", 32'(rx_if.busy), 32'h1);
        repeat (20) @(negedge clk);
        check("glitch_idle", 32'(rx_if.busy), 32'h0);
        check("glitch_data", 32'(rx_if.data), 32'h02);
        check("glitch_no_pulses", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 32'h0);

        // Reset mid-way through data bit 4 of 0xC3
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(((8'hC3 >> i) & 8'h01) != 8'h00);
        RsRx = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_data", 32'(rx_if.data), 32'h0);
        check("rst_valid_busy", {30'd0, rx_if.data_valid, rx_if.busy}, 32'h0);
        check("rst_pulses", {30'd0, rx_if.framing_err, rx_if.overrun}, 32'h0);
        RsRx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        f0 = ferr_cnt;
        send_frame(8'h81, 1, 1'b1);
        check("post_rst_data", 32'(rx_if.data), 32'h81);
        check("post_rst_valid", 32'(rx_if.data_valid), 32'h1);
        check("post_rst_no_ferr", 32'(ferr_cnt - f0), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
